// File: rtl/sync_pipe_pkg.sv
// Shared definitions for the sync_dff_pipe family: occupancy-counter sizing
// and the default reset value for data stages.
package sync_pipe_pkg;

   localparam int DEFAULT_RST_VAL = 0;

   // Width needed to count 0..depth; never narrower than one bit.
   function automatic int occ_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dff_en_srst.sv
// WIDTH-bit register with clock enable and synchronous reset to RST_VAL.
// Reset dominates enable.
module dff_en_srst #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         q_reg <= RST_VAL;
      end else if (en) begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/sync_dff_pipe.sv
// WIDTH x DEPTH register pipeline with per-stage valid bits, stall, flush and
// a registered occupancy count. DEPTH=1 is a plain enabled D flip-flop.
module sync_dff_pipe
   import sync_pipe_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              d,
   input  logic                          d_valid,
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   output logic [occ_width(DEPTH)-1:0]   occ,
   output logic                          busy
);

   localparam int OW = occ_width(DEPTH);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic             v_q    [DEPTH];
   logic             data_en;
   logic             v_srst;
   logic [OW-1:0]    occ_reg;
   logic [OW-1:0]    occ_next;
   logic             busy_reg;
   logic             busy_next;

   // Flush clears only the valid bits; data registers keep their contents.
   assign data_en = en & ~flush;
   assign v_srst  = rst | flush;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] data_in;
         logic             v_in;

         if (gi == 0) begin : g_head
            assign data_in = d;
            assign v_in    = d_valid;
         end else begin : g_body
            assign data_in = data_q[gi-1];
            assign v_in    = v_q[gi-1];
         end

         dff_en_srst #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
         ) u_data (
            .clk  (clk),
            .srst (rst),
            .en   (data_en),
            .d    (data_in),
            .q    (data_q[gi])
         );

         dff_en_srst #(
            .WIDTH   (1),
            .RST_VAL (1'b0)
         ) u_valid (
            .clk  (clk),
            .srst (v_srst),
            .en   (en),
            .d    (v_in),
            .q    (v_q[gi])
         );
      end
   endgenerate

   // One sample enters and one leaves per enabled edge, so occ moves by at most one.
   always_comb begin
      occ_next = occ_reg;
      case ({d_valid, v_q[DEPTH-1]})
         2'b10:   occ_next = occ_reg + OW'(1);
         2'b01:   occ_next = occ_reg - OW'(1);
         default: occ_next = occ_reg;
      endcase
      busy_next = (occ_next != '0);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occ_reg  <= '0;
         busy_reg <= 1'b0;
      end else if (en) begin
         occ_reg  <= occ_next;
         busy_reg <= busy_next;
      end
   end

   assign q       = data_q[DEPTH-1];
   assign q_valid = v_q[DEPTH-1];
   assign occ     = occ_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_sync_dff_pipe.sv
// Directed bench for sync_dff_pipe: a WIDTH=8/DEPTH=4 instance with a non-zero
// reset value and a WIDTH=1/DEPTH=1 instance driven between clock edges.
module tb_sync_dff_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DEPTH=4 instance
   logic       rst, en, flush, d_valid;
   logic [7:0] d, q;
   logic       q_valid, busy;
   logic [2:0] occ;

   sync_dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .q(q), .q_valid(q_valid), .occ(occ), .busy(busy)
   );

   // DEPTH=1 instance
   logic rst1, en1, flush1, d1, dv1, q1, qv1, busy1;
   logic [0:0] occ1;

   sync_dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst1), .en(en1), .flush(flush1), .d(d1), .d_valid(dv1),
      .q(q1), .q_valid(qv1), .occ(occ1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Drive one edge on the DEPTH=4 instance and check every output 1 ns after it.
   task automatic step(input string tag, input logic r, input logic f, input logic e,
                       input logic [7:0] dd, input logic dv,
                       input logic [7:0] eq, input logic eqv, input int eocc);
      rst = r; flush = f; en = e; d = dd; d_valid = dv;
      @(posedge clk);
      #1;
      $display("%-8s rst=%0d flush=%0d en=%0d d=%h dv=%0d -> q=%h qv=%0d occ=%0d busy=%0d",
               tag, r, f, e, dd, dv, q, q_valid, occ, busy);
      chk({tag, ".q"},    32'(q),       32'(eq));
      chk({tag, ".qv"},   32'(q_valid), 32'(eqv));
      chk({tag, ".occ"},  32'(occ),     32'(eocc));
      chk({tag, ".busy"}, 32'(busy),    32'(eocc != 0));
   endtask

   task automatic chk1(input string tag, input logic eq, input logic eqv, input logic eocc);
      $display("%-8s t=%0t d1=%0d rst1=%0d en1=%0d -> q1=%0d qv1=%0d occ1=%0d busy1=%0d",
               tag, $time, d1, rst1, en1, q1, qv1, occ1, busy1);
      chk({tag, ".q1"},    32'(q1),    32'(eq));
      chk({tag, ".qv1"},   32'(qv1),   32'(eqv));
      chk({tag, ".occ1"},  32'(occ1),  32'(eocc));
      chk({tag, ".busy1"}, 32'(busy1), 32'(eocc));
   endtask

   initial begin
      rst1 = 1'b1; en1 = 1'b1; flush1 = 1'b0; d1 = 1'b0; dv1 = 1'b0;

      // Reset, then drain reset values out with invalid zeros
      step("rst0",  1, 0, 1, 8'h33, 0, 8'hA5, 0, 0);
      step("rst1",  1, 0, 1, 8'h33, 0, 8'hA5, 0, 0);
      step("post1", 0, 0, 1, 8'h00, 0, 8'hA5, 0, 0);
      step("post2", 0, 0, 1, 8'h00, 0, 8'hA5, 0, 0);
      step("post3", 0, 0, 1, 8'h00, 0, 8'hA5, 0, 0);
      step("post4", 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      // Latency and order, including a full pipeline with d_valid=1
      step("lat1",  0, 0, 1, 8'h01, 1, 8'h00, 0, 1);
      step("lat2",  0, 0, 1, 8'h02, 1, 8'h00, 0, 2);
      step("lat3",  0, 0, 1, 8'h03, 1, 8'h00, 0, 3);
      step("lat4",  0, 0, 1, 8'h04, 1, 8'h01, 1, 4);
      step("lat5",  0, 0, 1, 8'h05, 1, 8'h02, 1, 4);
      step("drn1",  0, 0, 1, 8'h00, 0, 8'h03, 1, 3);
      step("drn2",  0, 0, 1, 8'h00, 0, 8'h04, 1, 2);
      step("drn3",  0, 0, 1, 8'h00, 0, 8'h05, 1, 1);
      step("drn4",  0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      // Stall
      step("stl_l1", 0, 0, 1, 8'h11, 1, 8'h00, 0, 1);
      step("stl_l2", 0, 0, 1, 8'h22, 1, 8'h00, 0, 2);
      step("stl_h1", 0, 0, 0, 8'h99, 1, 8'h00, 0, 2);
      step("stl_h2", 0, 0, 0, 8'h99, 1, 8'h00, 0, 2);
      step("stl_h3", 0, 0, 0, 8'h99, 1, 8'h00, 0, 2);
      step("stl_r1", 0, 0, 1, 8'h00, 0, 8'h00, 0, 2);
      step("stl_r2", 0, 0, 1, 8'h00, 0, 8'h11, 1, 2);
      step("stl_r3", 0, 0, 1, 8'h00, 0, 8'h22, 1, 1);
      step("stl_r4", 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      // Flush beats en; stale data still shifts but never valid, 8'h77 never captured
      step("fl_l1", 0, 0, 1, 8'hA1, 1, 8'h00, 0, 1);
      step("fl_l2", 0, 0, 1, 8'hA2, 1, 8'h00, 0, 2);
      step("fl_l3", 0, 0, 1, 8'hA3, 1, 8'h00, 0, 3);
      step("flush", 0, 1, 1, 8'h77, 1, 8'h00, 0, 0);
      step("fl_d1", 0, 0, 1, 8'h00, 0, 8'hA1, 0, 0);
      step("fl_d2", 0, 0, 1, 8'h00, 0, 8'hA2, 0, 0);
      step("fl_d3", 0, 0, 1, 8'h00, 0, 8'hA3, 0, 0);
      step("fl_d4", 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      // Reset mid-stream with a full pipeline
      step("mr_l1", 0, 0, 1, 8'hB1, 1, 8'h00, 0, 1);
      step("mr_l2", 0, 0, 1, 8'hB2, 1, 8'h00, 0, 2);
      step("mr_l3", 0, 0, 1, 8'hB3, 1, 8'h00, 0, 3);
      step("mr_l4", 0, 0, 1, 8'hB4, 1, 8'hB1, 1, 4);
      step("mr_rst", 1, 0, 1, 8'hFF, 1, 8'hA5, 0, 0);
      step("mr_n1", 0, 0, 1, 8'hC1, 1, 8'hA5, 0, 1);
      step("mr_n2", 0, 0, 1, 8'h00, 0, 8'hA5, 0, 1);
      step("mr_n3", 0, 0, 1, 8'h00, 0, 8'hA5, 0, 1);
      step("mr_n4", 0, 0, 1, 8'h00, 0, 8'hC1, 1, 1);
      step("mr_n5", 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);

      // DEPTH=1: inputs move every 3 ns against edges 10 ns apart (now at edge E+1)
      rst1 = 1'b0; d1 = 1'b0; dv1 = 1'b0;
      #1 d1 = 1'b1; dv1 = 1'b1;               // E+2
      #3 d1 = 1'b0;                           // E+5
      #3 d1 = 1'b1;                           // E+8
      chk1("d1_pre", 1'b0, 1'b0, 1'b0);
      #3;                                     // E+11, edge E+10 sampled d1=1
      chk1("d1_e1", 1'b1, 1'b1, 1'b1);
      d1 = 1'b0;
      #3;                                     // E+14
      chk1("d1_mid", 1'b1, 1'b1, 1'b1);
      rst1 = 1'b1;
      #1;                                     // E+15, reset not yet sampled
      chk1("d1_rstw", 1'b1, 1'b1, 1'b1);
      #6;                                     // E+21, edge E+20 applied reset
      chk1("d1_rst", 1'b0, 1'b0, 1'b0);
      rst1 = 1'b0; d1 = 1'b1; dv1 = 1'b1;
      #10;                                    // E+31
      chk1("d1_e3", 1'b1, 1'b1, 1'b1);
      en1 = 1'b0; d1 = 1'b0; dv1 = 1'b0;
      #10;                                    // E+41, stalled
      chk1("d1_hold", 1'b1, 1'b1, 1'b1);
      en1 = 1'b1;
      #10;                                    // E+51
      chk1("d1_e5", 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_dff_pipe.md
# sync_dff_pipe

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with synchronous active-high reset, programmable reset value, per-stage valid tracking, global advance enable (stall), flush and an occupancy count. It is the team's standard delay and retiming element, used wherever data must be held a fixed number of enabled cycles. DEPTH=1 degenerates to a synchronous-reset D flip-flop with enable.

## Interface
Parameters:
- WIDTH, 8: data width in bits, at least 1.
- DEPTH, 4: number of pipeline stages, at least 1.
- RST_VAL, 0: WIDTH-bit value loaded into every data stage on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable. 1 shifts the pipeline one stage; 0 holds all state.
- flush  in  1  synchronously invalidates every stage.
- d  in  WIDTH  input data, captured into stage 0.
- d_valid  in  1  qualifies d; captured alongside it.
- q  out  WIDTH  data of the last stage (DEPTH-1), driven directly from the register.
- q_valid  out  1  valid bit of the last stage.
- occ  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.
- busy  out  1  registered; equals (occ != 0).

## Operation
- State: data[0..DEPTH-1] (WIDTH each), v[0..DEPTH-1], occ register, busy register.
- Priority at each rising edge: rst, then flush, then en, then hold.
- rst=1: every data stage is set to RST_VAL, all v are set to 0, occ is set to 0 and busy to 0. flush, en and d are ignored.
- flush=1 (with rst=0): all v are set to 0, occ to 0 and busy to 0. Data registers keep their contents. en is ignored, and d/d_valid are not captured that cycle.
- en=1 (no rst, no flush):
  - data[0] takes d and v[0] takes d_valid.
  - data[i] takes data[i-1] and v[i] takes v[i-1], for i = 1..DEPTH-1.
  - occ next value is occ + d_valid - v[DEPTH-1], computed at occ width plus 1 and never wrapping. occ stays unchanged when both terms are 1.
- en=0: all state holds, including occ.
- Invalid stages still shift data. q shows stage data whatever q_valid is; consumers qualify q with q_valid.
- Invariant: occ always equals popcount(v). The bench checks this every cycle.

## Timing
- Latency: a sample presented with en=1 at edge k appears on q/q_valid after edge k+DEPTH-1 completes. That is DEPTH enabled edges including the capturing edge. Edges with en=0 add no progress.
- All outputs are registered; there is no combinational path from input to output.
- Reset values: q = RST_VAL, q_valid = 0, occ = 0, busy = 0. These hold from the first edge with rst=1 onward; outputs are undefined before the first reset edge.
- Reset mid-stream: in-flight data is lost. The edge after rst deasserts behaves as an ordinary en/flush edge.
- flush and en asserted together: flush wins; nothing is captured.
- Full pipeline (occ=DEPTH) with en=1 and d_valid=1: occ stays at DEPTH and the oldest sample leaves on q.
- DEPTH=1: q follows d one enabled edge later, and occ is 1 bit wide.

## Structure
- Shared package sync_pipe_pkg holds:
  - a function occ_width(depth) returning $clog2(depth+1), with a minimum of 1;
  - a default reset-value constant.
- One sub-module, dff_en_srst: a WIDTH-bit register with enable and synchronous reset to RST_VAL. It is instantiated DEPTH times for data and DEPTH times (WIDTH=1, RST_VAL=0) for valid.
- The top level wraps these with the flush override, the occ counter and the busy register.

## Test plan
- Reset: WIDTH=8, DEPTH=4, RST_VAL=8'hA5. Hold rst=1 for 2 edges, then 0, with en=1 and d_valid=0 -> q=8'hA5, q_valid=0, occ=0 and busy=0 for all cycles; q stays 8'hA5 until 4 enabled edges after rst deasserts.
- Latency and order: stream d=1,2,3,4,5 with d_valid=1 and en=1 every edge -> q_valid rises after the 4th edge with q=1, followed by 2,3,4,5; occ reads 1,2,3,4,4.
- Stall: load d=8'h11 and 8'h22, drop en for 3 edges, then resume -> all outputs frozen during the stall; 8'h11 still appears after exactly 4 enabled edges.
- Flush and priority: with occ=3, assert flush=1 and en=1 with d=8'h77 and d_valid=1 -> next edge gives occ=0 and q_valid=0; 8'h77 never appears valid on q.
- Reset mid-stream: with occ=4, pulse rst for 1 edge while en=1 -> q=RST_VAL, occ=0, q_valid=0; new data loaded afterwards emerges 4 enabled edges later.
- DEPTH=1, WIDTH=1: toggle d 1,0,1,0 at 3 ns spacing against a 10 ns clock -> q follows d sampled at each rising edge, and an rst asserted between edges has no effect until the next edge.
